evt_packer: RTL and testbench

Parametrised slow-path event packetiser for the BPM signal chain. It sits between the position/power results and the slow (MB-read) FIFO, on the 10 MHz processing clock. On each result strobe it snapshots all per-event results and streams a fixed-format 32-bit packet into the FIFO. Unlike the fixed 16-word packer it generalises channel count, honours FIFO back-pressure mid-packet, counts dropped events, and can optionally pack calibration events and append a checksum.

---
 rtl/evt_packer.sv | 194 +++++++++++++++++++
 tb/tb_evt_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_packer.sv
// Slow-path event packetiser: snapshots per-event results on evt_rdy and streams a
// fixed-format 32-bit packet into the MB-read FIFO. Define EVT_PACKER_CHECKSUM_EN to append an XOR checksum word.
module evt_packer #(
  parameter int unsigned NUM_CH = 4,
  parameter logic [31:0] PID    = 32'h4142504d,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   evt_rdy,
  input  logic                   cal_flag,
  input  logic                   pack_cal,
  input  logic                   rst_cnt,
  input  logic [15:0]            status,
  input  logic [47:0]            pos_xys,
  input  logic [NUM_CH*32-1:0]   power,
  input  logic [NUM_CH*16-1:0]   ch_max,
  input  logic                   fifo_afull,
  input  logic                   fifo_full,
  output logic                   fifo_wr,
  output logic [31:0]            fifo_din,
  output logic                   busy,
  output logic                   pkt_done,
  output logic [CNT_W-1:0]       evt_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int unsigned NMAX = (NUM_CH + 1) / 2;
`ifdef EVT_PACKER_CHECKSUM_EN
  localparam int unsigned CSUM = 1;
`else
  localparam int unsigned CSUM = 0;
`endif
  localparam int unsigned LEN   = 4 + NUM_CH + NMAX + CSUM;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned PAD_W = 32 * NMAX;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);
  localparam logic [7:0]       LEN8 = 8'(LEN);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt, nidx;
  logic                wr_nxt, busy_nxt, done_nxt;
  logic [31:0]         din_nxt, word_nxt, csum, csum_nxt;
  logic                snap_en, cnt_inc, drop_inc, eligible, accept;

  logic [15:0]         snap_status;
  logic [CNT_W-1:0]    snap_cnt;
  logic [47:0]         snap_pos;
  logic [NUM_CH*32-1:0] snap_power;
  logic [NUM_CH*16-1:0] snap_max;
  logic [7:0]          snap_type;
  logic [PAD_W-1:0]    max_pad;

  assign eligible = evt_rdy & (~cal_flag | pack_cal);
  assign accept   = fifo_wr & ~fifo_full;
  assign nidx     = idx + 1'b1;

  // Odd channel counts leave the low half of the last max word zero.
  always_comb begin
    max_pad = '0;
    max_pad[NUM_CH*16-1:0] = snap_max;
  end

  always_comb begin
    int unsigned n, k;
    n = 32'(nidx);
    k = 0;
    word_nxt = '0;
    if (n == 1)
      word_nxt = {snap_status, snap_cnt};
    else if (n == 2)
      word_nxt = snap_pos[47:16];
    else if (n == 3)
      word_nxt = {snap_pos[15:0], snap_type, LEN8};
    else if (n < 4 + NUM_CH)
      word_nxt = snap_power[(n-4)*32 +: 32];
    else if (n < 4 + NUM_CH + NMAX) begin
      k = n - 4 - NUM_CH;
      word_nxt = {max_pad[(2*k)*16 +: 16], max_pad[(2*k+1)*16 +: 16]};
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_nxt    = fifo_wr;
    din_nxt   = fifo_din;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    csum_nxt  = csum;
    snap_en   = 1'b0;
    cnt_inc   = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (eligible) begin
          if (!fifo_afull) begin
            snap_en   = 1'b1;
            state_nxt = SEND;
            idx_nxt   = '0;
            wr_nxt    = 1'b1;
            din_nxt   = PID;
            busy_nxt  = 1'b1;
            csum_nxt  = '0;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      SEND: begin
        drop_inc = eligible;
        if (accept) begin
          csum_nxt = csum ^ fifo_din;
          if (idx == LAST) begin
            state_nxt = DONE;
            wr_nxt    = 1'b0;
            din_nxt   = '0;
            done_nxt  = 1'b1;
            cnt_inc   = 1'b1;
          end else begin
            idx_nxt = nidx;
`ifdef EVT_PACKER_CHECKSUM_EN
            din_nxt = (nidx == LAST) ? csum_nxt : word_nxt;
`else
            din_nxt = word_nxt;
`endif
          end
        end
      end
      DONE: begin
        drop_inc  = eligible;
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
      csum     <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      fifo_wr  <= wr_nxt;
      fifo_din <= din_nxt;
      busy     <= busy_nxt;
      pkt_done <= done_nxt;
      csum     <= csum_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_status <= '0;
      snap_cnt    <= '0;
      snap_pos    <= '0;
      snap_power  <= '0;
      snap_max    <= '0;
      snap_type   <= '0;
    end else if (snap_en) begin
      snap_status <= status;
      snap_cnt    <= evt_cnt;
      snap_pos    <= pos_xys;
      snap_power  <= power;
      snap_max    <= ch_max;
      snap_type   <= {7'd0, cal_flag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (rst_cnt) begin
      evt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (cnt_inc)
        evt_cnt <= evt_cnt + 1'b1;
      if (drop_inc && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_evt_packer.sv
// Directed bench for evt_packer (NUM_CH=4): packet contents, timing, back-pressure,
// drops, calibration handling, counter clear and mid-packet reset.
module tb_evt_packer;

  localparam int NUM_CH = 4;
`ifdef EVT_PACKER_CHECKSUM_EN
  localparam int LEN = 11;
`else
  localparam int LEN = 10;
`endif

  logic        clk, rst_n, evt_rdy, cal_flag, pack_cal, rst_cnt;
  logic [15:0] status;
  logic [47:0] pos_xys;
  logic [NUM_CH*32-1:0] power;
  logic [NUM_CH*16-1:0] ch_max;
  logic        fifo_afull, fifo_full, fifo_wr, busy, pkt_done;
  logic [31:0] fifo_din;
  logic [15:0] evt_cnt, drop_cnt;

  evt_packer #(.NUM_CH(NUM_CH), .PID(32'h4142504d), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .evt_rdy(evt_rdy), .cal_flag(cal_flag),
    .pack_cal(pack_cal), .rst_cnt(rst_cnt), .status(status), .pos_xys(pos_xys),
    .power(power), .ch_max(ch_max), .fifo_afull(fifo_afull), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .busy(busy), .pkt_done(pkt_done),
    .evt_cnt(evt_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wq[$];
  int          wcyc[$];
  int          done_cyc, done_n;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wr && !fifo_full) begin
        wq.push_back(fifo_din);
        wcyc.push_back(cyc);
      end
      if (pkt_done) begin
        done_cyc = cyc;
        done_n   = done_n + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    wcyc.delete();
    done_n   = 0;
    done_cyc = -1;
  endtask

  logic [31:0] exp_w[LEN];

  // Hand-computed words for the reference event; cnt/type patched per packet.
  task automatic build_exp(input logic [15:0] cnt, input logic [7:0] typ);
    logic [31:0] x;
    exp_w[0] = 32'h4142504d;
    exp_w[1] = {16'h0003, cnt};
    exp_w[2] = 32'h0010FFF0;
    exp_w[3] = {16'h0100, typ, 8'(LEN)};
    exp_w[4] = 32'd1;
    exp_w[5] = 32'd2;
    exp_w[6] = 32'd3;
    exp_w[7] = 32'd4;
    exp_w[8] = 32'h000A000B;
    exp_w[9] = 32'h000C000D;
`ifdef EVT_PACKER_CHECKSUM_EN
    x = '0;
    for (int i = 0; i < 10; i++) x = x ^ exp_w[i];
    exp_w[10] = x;
`else
    x = '0;
`endif
  endtask

  task automatic set_evt();
    status  = 16'h0003;
    pos_xys = {16'h0010, 16'hFFF0, 16'h0100};
    power   = {32'd4, 32'd3, 32'd2, 32'd1};
    ch_max  = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
  endtask

  task automatic fire(output int t0);
    evt_rdy = 1'b1;
    t0 = cyc;
    step(1);
    evt_rdy = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && done_n == 0; i++) step(1);
    check({tag, "_done_seen"}, 32'(done_n), 32'd1);
  endtask

  task automatic check_pkt(input string tag);
    check({tag, "_nwords"}, 32'(wq.size()), 32'(LEN));
    for (int i = 0; i < LEN && i < wq.size(); i++)
      check($sformatf("%s_w%0d", tag, i), wq[i], exp_w[i]);
  endtask

  int t0;

  initial begin
    rst_n = 1'b0; evt_rdy = 1'b0; cal_flag = 1'b0; pack_cal = 1'b0; rst_cnt = 1'b0;
    fifo_afull = 1'b0; fifo_full = 1'b0;
    set_evt();
    clear_mon();
    step(3);
    check("rst_wr", 32'(fifo_wr), 32'd0);
    check("rst_din", fifo_din, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_evt", 32'(evt_cnt), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    step(2);

    // single event, contiguous timing
    clear_mon();
    build_exp(16'd0, 8'h00);
    fire(t0);
    check("t1_busy_rise", 32'(busy), 32'd1);
    check("t1_pid_now", fifo_din, 32'h4142504d);
    wait_done("t1");
    check_pkt("t1");
    if (wcyc.size() == LEN) begin
      check("t1_first_cyc", 32'(wcyc[0]), 32'(t0 + 1));
      check("t1_last_cyc", 32'(wcyc[LEN-1]), 32'(t0 + LEN));
    end
    check("t1_done_cyc", 32'(done_cyc), 32'(t0 + LEN + 1));
    check("t1_evt_cnt", 32'(evt_cnt), 32'd1);
    check("t1_busy_fall", 32'(busy), 32'd0);

    // back-pressure on word 5 for 3 cycles, inputs scrambled mid-packet
    clear_mon();
    build_exp(16'd1, 8'h00);
    fire(t0);
    status = 16'hDEAD;
    power  = '1;
    step(5);
    fifo_full = 1'b1;
    step(1);
    check("t2_hold_wr", 32'(fifo_wr), 32'd1);
    check("t2_hold_din", fifo_din, 32'd2);
    step(2);
    fifo_full = 1'b0;
    wait_done("t2");
    check_pkt("t2");
    if (wcyc.size() == LEN) check("t2_w5_cyc", 32'(wcyc[5]), 32'(t0 + 9));
    check("t2_done_cyc", 32'(done_cyc), 32'(t0 + LEN + 4));
    set_evt();

    // overload: second strobe mid-packet, then one while afull
    clear_mon();
    build_exp(16'd2, 8'h00);
    fire(t0);
    step(3);
    evt_rdy = 1'b1;
    step(1);
    evt_rdy = 1'b0;
    wait_done("t3");
    check_pkt("t3");
    fifo_afull = 1'b1;
    evt_rdy = 1'b1;
    step(1);
    evt_rdy = 1'b0;
    fifo_afull = 1'b0;
    step(3);
    check("t3_no_extra", 32'(wq.size()), 32'(LEN));
    check("t3_drop", 32'(drop_cnt), 32'd2);
    check("t3_evt", 32'(evt_cnt), 32'd3);

    // calibration ignored, then packed
    clear_mon();
    cal_flag = 1'b1;
    fire(t0);
    step(3);
    check("t4_ign_nwords", 32'(wq.size()), 32'd0);
    check("t4_ign_evt", 32'(evt_cnt), 32'd3);
    check("t4_ign_drop", 32'(drop_cnt), 32'd2);
    pack_cal = 1'b1;
    build_exp(16'd3, 8'h01);
    fire(t0);
    cal_flag = 1'b0;
    wait_done("t4");
    check_pkt("t4");
    check("t4_evt", 32'(evt_cnt), 32'd4);
    pack_cal = 1'b0;

    // counter clear coincident with the evt_cnt increment
    clear_mon();
    build_exp(16'd4, 8'h00);
    fire(t0);
    step(LEN - 1);
    rst_cnt = 1'b1;
    step(1);
    rst_cnt = 1'b0;
    check("t5_evt_clr", 32'(evt_cnt), 32'd0);
    check("t5_drop_clr", 32'(drop_cnt), 32'd0);
    wait_done("t5");
    check_pkt("t5");

    // reset during word 4
    clear_mon();
    fire(t0);
    step(4);
    check("t6_w4_now", fifo_din, 32'd1);
    #10;
    rst_n = 1'b0;
    #1;
    check("t6_wr", 32'(fifo_wr), 32'd0);
    check("t6_din", fifo_din, 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(pkt_done), 32'd0);
    step(3);
    rst_n = 1'b1;
    step(3);
    check("t6_nwords", 32'(wq.size()), 32'd4);
    check("t6_no_done", 32'(done_n), 32'd0);
    check("t6_idle_wr", 32'(fifo_wr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
